operate_seq: RTL and testbench

OPERATE_SEQ -- requirements
Module: operate_seq

---
 rtl/lc3_ctrl_pkg.sv | 16 +
 rtl/mem_wait_timer.sv | 15 +
 rtl/operate_seq.sv | 95 +++++++++
 tb/tb_operate_seq.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/lc3_ctrl_pkg.sv
// lc3_ctrl_pkg: shared FSM states, opcodes, ALU codes and limits for the operate-sequence controller
package lc3_ctrl_pkg;
  typedef enum logic [3:0] {
    HALTED, FETCH1, FETCH2, FETCH3, DECODE, EXEC_ADD, EXEC_AND, EXEC_NOT, PAUSE1, PAUSE2
  } state_t;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_PAUSE = 4'b1101;
  localparam logic [1:0] ALUK_ADD = 2'b00;
  localparam logic [1:0] ALUK_AND = 2'b01;
  localparam logic [1:0] ALUK_NOT = 2'b10;
  localparam logic [1:0] ALUK_PASSA = 2'b11;
  localparam logic [1:0] PCMUX_INC = 2'b00;
  localparam logic [3:0] WAIT_LIMIT = 4'hf;
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: 4-bit memory wait counter (clk, rst, clear, enable -> count, expire at WAIT_LIMIT)
module mem_wait_timer
  import lc3_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  output logic [3:0] count,
  output logic       expire
);
  always_ff @(posedge clk)
    count <= (rst || clear) ? 4'd0 : enable ? count + 4'd1 : count;
  assign expire = count == WAIT_LIMIT;
endmodule

// File: rtl/operate_seq.sv
// operate_seq: Moore control FSM for fetch/decode/ADD/AND/NOT/PAUSE (Clk, Reset, Run, Continue, IR, Mem_Ready in; datapath loads, gates, mux selects, Mem_OE, Halted/Paused/Mem_Err out)
module operate_seq
  import lc3_ctrl_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Run,
  input  logic        Continue,
  input  logic [15:0] IR,
  input  logic        Mem_Ready,
  output logic        LD_MAR,
  output logic        LD_MDR,
  output logic        LD_IR,
  output logic        LD_PC,
  output logic        LD_REG,
  output logic        LD_CC,
  output logic        LD_LED,
  output logic        GatePC,
  output logic        GateMDR,
  output logic        GateALU,
  output logic        SR2MUX_Sel,
  output logic [1:0]  ALUK,
  output logic [1:0]  PCMUX,
  output logic        DRMUX,
  output logic        SR1MUX,
  output logic        Mem_OE,
  output logic        Halted,
  output logic        Paused,
  output logic        Mem_Err
);
  state_t state, next;
  logic mem_err, led_done, expire, exec, alu2;
  logic [3:0] wait_cnt;
  logic unused_bits;
  assign unused_bits = ^{IR[11:6], IR[4:0], wait_cnt};
  mem_wait_timer u_timer (
    .clk(Clk),
    .rst(Reset),
    .clear(state != FETCH2),
    .enable(state == FETCH2 && !Mem_Ready),
    .count(wait_cnt),
    .expire(expire)
  );
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= HALTED;
      mem_err <= 1'b0;
      led_done <= 1'b0;
    end else begin
      state <= next;
      if (state == FETCH2 && !Mem_Ready && expire) mem_err <= 1'b1;
      led_done <= state == PAUSE1;
    end
  end
  always_comb begin
    next = state;
    case (state)
      HALTED:   next = Run ? FETCH1 : HALTED;
      FETCH1:   next = FETCH2;
      FETCH2:   next = Mem_Ready ? FETCH3 : expire ? HALTED : FETCH2;
      FETCH3:   next = DECODE;
      DECODE:   next = IR[15:12] == OP_ADD ? EXEC_ADD :
                       IR[15:12] == OP_AND ? EXEC_AND :
                       IR[15:12] == OP_NOT ? EXEC_NOT :
                       IR[15:12] == OP_PAUSE ? PAUSE1 : FETCH1;
      EXEC_ADD, EXEC_AND, EXEC_NOT: next = FETCH1;
      PAUSE1:   next = Continue ? PAUSE2 : PAUSE1;
      PAUSE2:   next = Continue ? PAUSE2 : FETCH1;
      default:  next = HALTED;
    endcase
  end
  assign exec = state == EXEC_ADD || state == EXEC_AND || state == EXEC_NOT;
  assign alu2 = state == EXEC_ADD || state == EXEC_AND;
  assign LD_MAR = state == FETCH1;
  assign LD_PC = state == FETCH1;
  assign GatePC = state == FETCH1;
  assign LD_MDR = state == FETCH2;
  assign Mem_OE = state == FETCH2;
  assign LD_IR = state == FETCH3;
  assign GateMDR = state == FETCH3;
  assign LD_REG = exec;
  assign LD_CC = exec;
  assign GateALU = exec;
  assign SR1MUX = alu2;
  assign SR2MUX_Sel = alu2 && IR[5];
  assign ALUK = state == EXEC_ADD ? ALUK_ADD : state == EXEC_AND ? ALUK_AND :
                state == EXEC_NOT ? ALUK_NOT : ALUK_PASSA;
  assign PCMUX = PCMUX_INC;
  assign DRMUX = 1'b0;
  // LED loads only on the first PAUSE1 cycle; led_done remembers we were already there
  assign LD_LED = state == PAUSE1 && !led_done;
  assign Paused = state == PAUSE1 || state == PAUSE2;
  assign Halted = state == HALTED;
  assign Mem_Err = mem_err;
endmodule

// File: tb/tb_operate_seq.sv
// tb_operate_seq: randomized self-checking bench for operate_seq against a per-phase instruction model
module tb_operate_seq;
  logic Clk = 1'b0;
  logic Reset, Run, Continue, Mem_Ready;
  logic [15:0] IR;
  logic LD_MAR, LD_MDR, LD_IR, LD_PC, LD_REG, LD_CC, LD_LED, GatePC, GateMDR, GateALU;
  logic SR2MUX_Sel, DRMUX, SR1MUX, Mem_OE, Halted, Paused, Mem_Err;
  logic [1:0] ALUK, PCMUX;
  operate_seq dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .IR(IR), .Mem_Ready(Mem_Ready),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_PC(LD_PC), .LD_REG(LD_REG),
    .LD_CC(LD_CC), .LD_LED(LD_LED), .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU),
    .SR2MUX_Sel(SR2MUX_Sel), .ALUK(ALUK), .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX),
    .Mem_OE(Mem_OE), .Halted(Halted), .Paused(Paused), .Mem_Err(Mem_Err)
  );
  always #5 Clk = ~Clk;
  localparam int PH_HALT = 0, PH_F1 = 1, PH_F2 = 2, PH_F3 = 3, PH_DEC = 4;
  localparam int PH_ADD = 5, PH_AND = 6, PH_NOT = 7, PH_P1 = 8, PH_P2 = 9;
  int n_cmp = 0, n_bad = 0;
  logic err_m;
  bit noise;
  bit halted;
  logic [20:0] obs;
  assign obs = {LD_MAR, LD_MDR, LD_IR, LD_PC, LD_REG, LD_CC, LD_LED, GatePC, GateMDR, GateALU,
                SR2MUX_Sel, ALUK, PCMUX, DRMUX, SR1MUX, Mem_OE, Halted, Paused, Mem_Err};
  function automatic logic [20:0] exp_out(int ph, logic [15:0] ir, logic led, logic err);
    logic mar = 0, mdr = 0, ldir = 0, pc = 0, ldreg = 0, cc = 0, gpc = 0, gmdr = 0, galu = 0;
    logic sr2 = 0, sr1 = 0, oe = 0, paused = 0, hlt = 0;
    logic [1:0] aluk = 2'b11;
    case (ph)
      PH_HALT: hlt = 1;
      PH_F1: begin mar = 1; pc = 1; gpc = 1; end
      PH_F2: begin mdr = 1; oe = 1; end
      PH_F3: begin ldir = 1; gmdr = 1; end
      PH_ADD, PH_AND, PH_NOT: begin
        ldreg = 1; cc = 1; galu = 1;
        aluk = ph == PH_ADD ? 2'd0 : ph == PH_AND ? 2'd1 : 2'd2;
        sr1 = ph != PH_NOT;
        sr2 = ph != PH_NOT && ir[5];
      end
      PH_P1, PH_P2: paused = 1;
      default: ;
    endcase
    return {mar, mdr, ldir, pc, ldreg, cc, led, gpc, gmdr, galu, sr2, aluk, 2'b00, 1'b0, sr1, oe,
            hlt, paused, err};
  endfunction
  task automatic chk(input string tag, input logic [20:0] got, input logic [20:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic see(input string tag, input int ph, input logic led = 1'b0);
    chk(tag, obs, exp_out(ph, IR, led, err_m));
  endtask
  task automatic tick;
    if (noise) Run = 1'($urandom_range(0, 1));
    @(posedge Clk);
    #1;
  endtask
  task automatic start;
    noise = 0;
    Run = 1;
    tick;
    Run = 0;
    see("start", PH_F1);
  endtask
  // Expects the DUT in FETCH1; w = FETCH2 cycle index (0-based) at which Mem_Ready rises, >15 means never
  task automatic run_instr(input logic [15:0] ir, input int w, input int h1, input int h2);
    int ph;
    IR = ir;
    noise = 1;
    Mem_Ready = 0;
    Continue = 0;
    halted = 0;
    tick;
    for (int n = 0; n < 16; n++) begin
      see("fetch2", PH_F2);
      Mem_Ready = n == w;
      tick;
      if (n == w) break;
      if (n == 15) begin
        err_m = 1;
        noise = 0;
        Run = 0;
        Mem_Ready = 0;
        see("timeout", PH_HALT);
        halted = 1;
        return;
      end
    end
    Mem_Ready = 0;
    see("fetch3", PH_F3);
    tick;
    see("decode", PH_DEC);
    tick;
    ph = ir[15:12] == 4'b0001 ? PH_ADD : ir[15:12] == 4'b0101 ? PH_AND :
         ir[15:12] == 4'b1001 ? PH_NOT : ir[15:12] == 4'b1101 ? PH_P1 : PH_F1;
    if (ph == PH_P1) begin
      see("pause_led", PH_P1, 1'b1);
      for (int i = 0; i < h1; i++) begin
        tick;
        see("pause_hold", PH_P1);
      end
      Continue = 1;
      tick;
      see("pause2", PH_P2);
      for (int i = 0; i < h2; i++) begin
        tick;
        see("pause2_hold", PH_P2);
      end
      Continue = 0;
      tick;
      see("resume", PH_F1);
    end else if (ph != PH_F1) begin
      see("exec", ph);
      tick;
      see("after_exec", PH_F1);
    end else
      see("nop_fetch", PH_F1);
    noise = 0;
  endtask
  initial begin
    noise = 0;
    err_m = 0;
    Reset = 1; Run = 1; Continue = 1; Mem_Ready = 1; IR = 16'h0000;
    tick;
    tick;
    see("reset", PH_HALT);
    Reset = 0; Run = 0; Continue = 0; Mem_Ready = 0;
    tick;
    see("idle", PH_HALT);
    start;
    run_instr(16'h1283, 0, 0, 0);
    run_instr(16'h5AA5, 0, 0, 0);
    run_instr(16'h0000, 2, 0, 0);
    run_instr(16'h9FFF, 1, 0, 0);
    run_instr(16'hD0FF, 0, 2, 3);
    run_instr(16'hD0FF, 3, 0, 0);
    run_instr(16'h1283, 99, 0, 0);
    tick;
    see("halt_stay", PH_HALT);
    start;
    run_instr(16'h1020, 3, 0, 0);
    Mem_Ready = 0;
    IR = 16'h1283;
    tick;
    see("pre_rst_f2", PH_F2);
    Reset = 1; Run = 1; Continue = 1; Mem_Ready = 1;
    tick;
    err_m = 0;
    see("rst_fetch2", PH_HALT);
    Reset = 0; Run = 0; Continue = 0; Mem_Ready = 0;
    start;
    run_instr(16'h1283, 15, 0, 0);
    IR = 16'hD0FF;
    Mem_Ready = 1;
    repeat (4) tick;
    Mem_Ready = 0;
    see("pre_rst_p1", PH_P1, 1'b1);
    Reset = 1; Run = 1; Continue = 1;
    tick;
    see("rst_pause1", PH_HALT);
    Reset = 0; Run = 0; Continue = 0;
    start;
    for (int k = 0; k < 40; k++) begin
      logic [15:0] ir;
      int sel;
      ir = 16'($urandom);
      sel = $urandom_range(0, 4);
      if (sel < 4) ir[15:12] = sel == 0 ? 4'h1 : sel == 1 ? 4'h5 : sel == 2 ? 4'h9 : 4'hD;
      run_instr(ir, ($urandom_range(0, 7) == 0) ? 16 : $urandom_range(0, 15),
                $urandom_range(0, 3), $urandom_range(0, 3));
      if (halted) begin
        tick;
        see("rand_halt", PH_HALT);
        start;
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
